// File: rtl/polar_to_cart_cordic.sv
// Iterative rotation-mode CORDIC: polar (r, whole degrees) in, unsigned Cartesian (x, y) out.
// One micro-rotation per enabled cycle behind a start/busy/done handshake.
module polar_to_cart_cordic #(
    parameter int ITER = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] r_in,
    input  logic [7:0] theta_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] x_out,
    output logic [7:0] y_out
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;
    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);
    // 155/256 pre-scales r by the inverse CORDIC gain, so no correction multiply at the end.
    localparam logic [15:0] GAIN_COMP = 16'd155;

    logic [1:0]         state_q, state_d;
    logic [3:0]         iter_q, iter_d;
    logic signed [17:0] x_q, x_d, y_q, y_d;
    logic signed [15:0] z_q, z_d;
    logic               done_q, done_d;
    logic [7:0]         x_out_q, x_out_d, y_out_q, y_out_d;
    logic [7:0]         theta_clamped;
    logic signed [17:0] x_shift, y_shift;

    // atan(2^-i) in degrees with 8 fraction bits.
    function automatic logic signed [15:0] atan_deg(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_deg = 16'sd11520;
            4'd1:    atan_deg = 16'sd6801;
            4'd2:    atan_deg = 16'sd3593;
            4'd3:    atan_deg = 16'sd1824;
            4'd4:    atan_deg = 16'sd916;
            4'd5:    atan_deg = 16'sd458;
            4'd6:    atan_deg = 16'sd229;
            4'd7:    atan_deg = 16'sd115;
            4'd8:    atan_deg = 16'sd57;
            4'd9:    atan_deg = 16'sd29;
            4'd10:   atan_deg = 16'sd14;
            4'd11:   atan_deg = 16'sd7;
            default: atan_deg = 16'sd0;
        endcase
    endfunction

    function automatic logic [7:0] round_sat(input logic signed [17:0] v);
        logic signed [17:0] rounded;
        rounded = (v + 18'sd128) >>> 8;
        if (rounded < 18'sd0)
            round_sat = 8'd0;
        else if (rounded > 18'sd255)
            round_sat = 8'd255;
        else
            round_sat = rounded[7:0];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d       = state_q;
        iter_d        = iter_q;
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        x_out_d       = x_out_q;
        y_out_d       = y_out_q;
        done_d        = 1'b0;
        theta_clamped = (theta_in > 8'd90) ? 8'd90 : theta_in;
        x_shift       = x_q >>> iter_q;
        y_shift       = y_q >>> iter_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = signed'({2'b00, {8'd0, r_in} * GAIN_COMP});
                    y_d     = '0;
                    z_d     = signed'({theta_clamped, 8'd0});
                    iter_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Residual angle sign picks the rotation direction; both shifts use pre-update x/y.
                if (!z_q[15]) begin
                    x_d = x_q - y_shift;
                    y_d = y_q + x_shift;
                    z_d = z_q - atan_deg(iter_q);
                end else begin
                    x_d = x_q + y_shift;
                    y_d = y_q - x_shift;
                    z_d = z_q + atan_deg(iter_q);
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == LAST_ITER)
                    state_d = S_FINISH;
            end
            S_FINISH: begin
                x_out_d = round_sat(x_q);
                y_out_d = round_sat(y_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else if (ena) begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            done_q  <= done_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign x_out = x_out_q;
    assign y_out = y_out_q;

endmodule

// File: tb/tb_polar_to_cart_cordic.sv
// Self-checking bench for polar_to_cart_cordic: a latency/result model compared every cycle,
// plus directed vectors with hand-derived ranges and a real-valued accuracy sweep.
module tb_polar_to_cart_cordic;
    localparam int  ITER = 12;
    localparam int  LAT  = ITER + 1;
    localparam real PI   = 3.14159265358979;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] r_in = '0;
    logic [7:0] theta_in = '0;
    logic       busy, done;
    logic [7:0] x_out, y_out;

    int n_checks = 0;
    int n_pass   = 0;

    polar_to_cart_cordic #(.ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .r_in(r_in), .theta_in(theta_in),
        .busy(busy), .done(done), .x_out(x_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- reference model ----------------
    int atan_tab [0:11] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7};

    function automatic int sat8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Rotation-mode CORDIC in plain integer arithmetic; returns {x, y}.
    function automatic logic [15:0] model_xy(input int r, input int th);
        int x, y, z, xn;
        if (th > 90) th = 90;
        x = r * 155;
        y = 0;
        z = th * 256;
        for (int i = 0; i < ITER; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i); y = y + (x >>> i); z = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i); y = y - (x >>> i); z = z + atan_tab[i];
            end
            x = xn;
        end
        return {8'(sat8((x + 128) >>> 8)), 8'(sat8((y + 128) >>> 8))};
    endfunction

    // m_left counts enabled edges until the pending result appears; zero means idle.
    int          m_left = 0;
    logic [15:0] pend_xy = '0;
    logic        exp_done = 1'b0;
    logic [7:0]  exp_x = '0, exp_y = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            exp_done <= 1'b0;
            exp_x    <= '0;
            exp_y    <= '0;
        end else if (ena) begin
            exp_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_left  <= LAT;
                    pend_xy <= model_xy(int'(r_in), int'(theta_in));
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    exp_done <= 1'b1;
                    exp_x    <= pend_xy[15:8];
                    exp_y    <= pend_xy[7:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", int'(busy), int'(m_left != 0));
        check("cyc_done", int'(done), int'(exp_done));
        check("cyc_x", int'(x_out), int'(exp_x));
        check("cyc_y", int'(y_out), int'(exp_y));
    end

    // ---------------- stimulus helpers ----------------
    // Called at a point away from the clock edge; returns at the negedge where done is seen.
    task automatic convert(input int r, input int th, output int lat);
        r_in = 8'(r); theta_in = 8'(th); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        r_in = ~r_in; theta_in = ~theta_in;   // must not affect the running conversion
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic check_real(input string tag, input int r, input int th);
        real a;
        int  xr, yr;
        a  = real'((th > 90) ? 90 : th) * PI / 180.0;
        xr = int'($floor(real'(r) * $cos(a) + 0.5));
        yr = int'($floor(real'(r) * $sin(a) + 0.5));
        check_range({tag, "_xacc"}, int'(x_out), (xr > 2) ? xr - 2 : 0, (xr + 2 < 255) ? xr + 2 : 255);
        check_range({tag, "_yacc"}, int'(y_out), (yr > 2) ? yr - 2 : 0, (yr + 2 < 255) ? yr + 2 : 255);
    endtask

    task automatic directed(input string tag, input int r, input int th,
                            input int xlo, input int xhi, input int ylo, input int yhi);
        int lat;
        convert(r, th, lat);
        check({tag, "_lat"}, lat, LAT);
        check_range({tag, "_x"}, int'(x_out), xlo, xhi);
        check_range({tag, "_y"}, int'(y_out), ylo, yhi);
        check_real(tag, r, th);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nd, last_k, extra;

        // Reset with start asserted: nothing may leave IDLE.
        rst_n = 1'b0; start = 1'b1; r_in = 8'd200; theta_in = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        start = 1'b0;
        rst_n = 1'b1;

        directed("first_0deg", 200, 0,   198, 202, 0,   2);
        directed("axis_90deg", 200, 90,  0,   2,   198, 202);
        directed("diag_45deg", 100, 45,  69,  73,  69,  73);
        directed("r255_30deg", 255, 30,  219, 223, 125, 130);
        directed("zero_r",     0,   60,  0,   0,   0,   0);
        directed("clamp_90",   255, 90,  0,   2,   253, 255);
        directed("clamp_200",  255, 200, 0,   2,   253, 255);

        // Second start while busy is ignored: one done, first operands' result.
        fork
            convert(50, 20, lat);
            begin
                repeat (4) @(posedge clk);
                #1 r_in = 8'd250; theta_in = 8'd80; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check("busy_ign_lat", lat, LAT);
        check_real("busy_ign", 50, 20);
        count_dones(20, extra);
        check("busy_ign_extra", extra, 0);

        // start held high: each done cycle is IDLE, so the next edge accepts again,
        // giving done-to-done spacing of the latency plus that acceptance edge.
        start = 1'b1; r_in = 8'd10; theta_in = 8'd5;
        nd = 0; last_k = -1;
        for (int k = 0; k < 42; k++) begin
            @(posedge clk);
            #1 r_in = 8'(k * 7 + 3); theta_in = 8'(k * 3);
            @(negedge clk);
            if (done) begin
                nd++;
                if (last_k >= 0) check("held_gap", k - last_k, LAT + 1);
                last_k = k;
            end
        end
        start = 1'b0;
        check("held_dones", nd, 3);
        count_dones(LAT + 4, extra);
        check("held_drain", extra, 0);

        // ena low for 5 cycles mid-run stretches latency by exactly 5.
        fork
            convert(180, 37, lat);
            begin
                repeat (5) @(posedge clk);
                #1 ena = 1'b0;
                repeat (5) @(posedge clk);
                #1 ena = 1'b1;
            end
        join
        check("ena_lat", lat, LAT + 5);
        check_real("ena_gap", 180, 37);

        // Async reset mid-run: outputs clear, no done, next conversion is normal.
        r_in = 8'd120; theta_in = 8'd50; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_x", int'(x_out), 0);
        check("midrst_y", int'(y_out), 0);
        #2 rst_n = 1'b1;
        count_dones(20, extra);
        check("midrst_nodone", extra, 0);
        directed("after_rst", 120, 50, 75, 79, 90, 94);

        // Accuracy sweep against the real-valued model.
        foreach (atan_tab[j]) begin
            if (j < 3) begin
                int r;
                r = (j == 0) ? 1 : ((j == 1) ? 128 : 255);
                for (int th = 0; th <= 90; th++) begin
                    convert(r, th, lat);
                    check("sweep_lat", lat, LAT);
                    check_real("sweep", r, th);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
